// File: rtl/multi_oneshot.sv
// Multi-channel one-shot pulse generator. Each channel turns a trigger rising edge into a
// delayed pulse of programmable width, then an optional holdoff. Channels can be set as
// retriggerable, and report a done strobe and a sticky missed-edge flag.
module multi_oneshot #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DELAY_W = 12,
  parameter int unsigned WIDTH_W = 13,
  parameter int unsigned HOLD_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_CH-1:0]         enable_i,
  input  logic [NUM_CH-1:0]         trigger_i,
  input  logic [NUM_CH-1:0]         retrig_i,
  input  logic [NUM_CH*DELAY_W-1:0] cfg_delay_i,
  input  logic [NUM_CH*WIDTH_W-1:0] cfg_width_i,
  input  logic [HOLD_W-1:0]         cfg_holdoff_i,
  input  logic                      clear_missed_i,
  output logic [NUM_CH-1:0]         pulse_o,
  output logic [NUM_CH-1:0]         busy_o,
  output logic [NUM_CH-1:0]         done_o,
  output logic [NUM_CH-1:0]         missed_o
);

  localparam int unsigned DwMax = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam int unsigned CntW  = (DwMax > HOLD_W) ? DwMax : HOLD_W;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StPulse, StHoldoff} state_e;

  state_e              state_q [NUM_CH];
  state_e              state_d [NUM_CH];
  logic [CntW-1:0]     cnt_q   [NUM_CH];
  logic [CntW-1:0]     cnt_d   [NUM_CH];
  logic [WIDTH_W-1:0]  wid_q   [NUM_CH];
  logic [WIDTH_W-1:0]  wid_d   [NUM_CH];
  logic [HOLD_W-1:0]   hold_q  [NUM_CH];
  logic [HOLD_W-1:0]   hold_d  [NUM_CH];
  logic [DELAY_W-1:0]  cfg_delay_ch [NUM_CH];
  logic [WIDTH_W-1:0]  cfg_width_ch [NUM_CH];
  logic [NUM_CH-1:0]   pulse_q, pulse_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   missed_q, missed_d;
  logic [NUM_CH-1:0]   trig_prev_q;
  logic [NUM_CH-1:0]   trig_edge;
  logic [NUM_CH-1:0]   miss_set;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg
    assign cfg_delay_ch[g] = cfg_delay_i[g*DELAY_W +: DELAY_W];
    assign cfg_width_ch[g] = cfg_width_i[g*WIDTH_W +: WIDTH_W];
  end

  // Next-state logic for every channel FSM plus the shared missed-flag update.
  always_comb begin
    trig_edge = trigger_i & ~trig_prev_q;
    pulse_d   = pulse_q;
    done_d    = '0;
    miss_set  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      wid_d[i]   = wid_q[i];
      hold_d[i]  = hold_q[i];
      if (!enable_i[i]) begin
        // Disabled channels drop silently: no done, no missed, config latches kept.
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
        pulse_d[i] = 1'b0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            // A zero-width request is dropped without counting as missed.
            if (trig_edge[i] && (cfg_width_ch[i] != '0)) begin
              wid_d[i]  = cfg_width_ch[i];
              hold_d[i] = cfg_holdoff_i;
              if (cfg_delay_ch[i] == '0) begin
                state_d[i] = StPulse;
                cnt_d[i]   = CntW'(cfg_width_ch[i]) - CntOne;
                pulse_d[i] = 1'b1;
              end else begin
                state_d[i] = StDelay;
                cnt_d[i]   = CntW'(cfg_delay_ch[i]) - CntOne;
              end
            end
          end
          StDelay: begin
            miss_set[i] = trig_edge[i];
            if (cnt_q[i] == '0) begin
              state_d[i] = StPulse;
              cnt_d[i]   = CntW'(wid_q[i]) - CntOne;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          StPulse: begin
            // Retrigger reload beats terminal count so the pulse has no gap.
            if (trig_edge[i] && retrig_i[i] && (cfg_width_ch[i] != '0)) begin
              cnt_d[i] = CntW'(cfg_width_ch[i]) - CntOne;
            end else begin
              miss_set[i] = trig_edge[i];
              if (cnt_q[i] == '0) begin
                pulse_d[i] = 1'b0;
                done_d[i]  = 1'b1;
                if (hold_q[i] == '0) begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
                end else begin
                  state_d[i] = StHoldoff;
                  cnt_d[i]   = CntW'(hold_q[i]) - CntOne;
                end
              end else begin
                cnt_d[i] = cnt_q[i] - CntOne;
              end
            end
          end
          StHoldoff: begin
            miss_set[i] = trig_edge[i];
            if (cnt_q[i] == '0) begin
              state_d[i] = StIdle;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b0;
          end
        endcase
      end
    end
    // A new miss in the same cycle as a clear wins.
    missed_d = (missed_q & ~{NUM_CH{clear_missed_i}}) | miss_set;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      trig_prev_q <= '1;
      pulse_q     <= '0;
      done_q      <= '0;
      missed_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        wid_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      trig_prev_q <= trigger_i;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        wid_q[i]   <= wid_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  // Busy reflects any non-idle state.
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_o[i] = (state_q[i] != StIdle);
    end
  end

  assign pulse_o  = pulse_q;
  assign done_o   = done_q;
  assign missed_o = missed_q;

endmodule

// File: tb/tb_multi_oneshot.sv
// Scoreboard bench for multi_oneshot: stimulus queues expected pulses and level checks,
// a negedge monitor matches them against what the DUT presents.
module tb_multi_oneshot;

  localparam int NUM_CH  = 4;
  localparam int DELAY_W = 12;
  localparam int WIDTH_W = 13;
  localparam int HOLD_W  = 8;
  localparam int SEL_PULSE = 0, SEL_BUSY = 1, SEL_DONE = 2, SEL_MISSED = 3;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_CH-1:0]         enable, trigger, retrig;
  logic [NUM_CH*DELAY_W-1:0] cfg_delay;
  logic [NUM_CH*WIDTH_W-1:0] cfg_width;
  logic [HOLD_W-1:0]         cfg_holdoff;
  logic                      clear_missed;
  logic [NUM_CH-1:0]         pulse, busy, done, missed;

  typedef struct { int ch; int rise; int len; logic dn; } pexp_t;
  typedef struct { int at; int ch; int sel; logic val; } lvl_t;

  pexp_t sb_q[$];
  lvl_t  lvl_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic  stim_done = 1'b0;

  multi_oneshot #(
    .NUM_CH (NUM_CH),
    .DELAY_W(DELAY_W),
    .WIDTH_W(WIDTH_W),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .enable_i      (enable),
    .trigger_i     (trigger),
    .retrig_i      (retrig),
    .cfg_delay_i   (cfg_delay),
    .cfg_width_i   (cfg_width),
    .cfg_holdoff_i (cfg_holdoff),
    .clear_missed_i(clear_missed),
    .pulse_o       (pulse),
    .busy_o        (busy),
    .done_o        (done),
    .missed_o      (missed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_PULSE: return "pulse";
      SEL_BUSY:  return "busy";
      SEL_DONE:  return "done";
      default:   return "missed";
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Edge accepted at posedge number t.
  task automatic trig_at(input int ch, input int t);
    wait_until(t - 1);
    trigger[ch] = 1'b1;
    @(negedge clk);
    trigger[ch] = 1'b0;
  endtask

  task automatic set_ch(input int ch, input int d, input int w);
    cfg_delay[ch*DELAY_W +: DELAY_W] = DELAY_W'(d);
    cfg_width[ch*WIDTH_W +: WIDTH_W] = WIDTH_W'(w);
  endtask

  task automatic exp_pulse(input int ch, input int rise, input int len, input logic dn);
    pexp_t e;
    e.ch = ch; e.rise = rise; e.len = len; e.dn = dn;
    sb_q.push_back(e);
  endtask

  task automatic chk(input int at, input int ch, input int sel, input logic val);
    lvl_t l;
    l.at = at; l.ch = ch; l.sel = sel; l.val = val;
    lvl_q.push_back(l);
  endtask

  task automatic chk_all_zero(input int at);
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 4; s++) chk(at, c, s, 1'b0);
  endtask

  task automatic clear_all();
    clear_missed = 1'b1;
    for (int c = 0; c < NUM_CH; c++) chk(cyc + 1, c, SEL_MISSED, 1'b0);
    @(negedge clk);
    clear_missed = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int t2;
    int tend;
    reset_n = 1'b0; enable = '0; trigger = '0; retrig = '0;
    cfg_delay = '0; cfg_width = '0; cfg_holdoff = '0; clear_missed = 1'b0;
    trigger[3] = 1'b1;
    set_ch(3, 0, 4);
    repeat (3) @(negedge clk);
    chk_all_zero(cyc + 1);
    @(negedge clk);

    // Trigger held high through reset release is not an edge.
    reset_n = 1'b1;
    enable  = '1;
    chk(cyc + 2, 3, SEL_BUSY, 1'b0);
    chk(cyc + 3, 3, SEL_PULSE, 1'b0);
    repeat (4) @(negedge clk);
    trigger[3] = 1'b0;
    @(negedge clk);
    t = cyc + 2;
    exp_pulse(3, t, 4, 1'b1);
    trig_at(3, t);
    wait_until(t + 8);

    // Zero width: ignored, not busy, not missed.
    set_ch(3, 0, 0);
    t = cyc + 2;
    chk(t, 3, SEL_BUSY, 1'b0);
    chk(t + 1, 3, SEL_BUSY, 1'b0);
    chk(t + 2, 3, SEL_MISSED, 1'b0);
    trig_at(3, t);
    wait_until(t + 4);

    // Ch0: D=0 W=5 H=0.
    set_ch(0, 0, 5);
    cfg_holdoff = 8'd0;
    t = cyc + 2;
    exp_pulse(0, t, 5, 1'b1);
    chk(t, 0, SEL_BUSY, 1'b1);
    chk(t + 4, 0, SEL_BUSY, 1'b1);
    chk(t + 5, 0, SEL_BUSY, 1'b0);
    trig_at(0, t);
    wait_until(t + 8);

    // Ch1: D=3 W=2 H=4, edge in holdoff missed, edge after idle return accepted.
    set_ch(1, 3, 2);
    cfg_holdoff = 8'd4;
    t = cyc + 2;
    exp_pulse(1, t + 3, 2, 1'b1);
    chk(t + 5, 1, SEL_MISSED, 1'b0);
    chk(t + 6, 1, SEL_MISSED, 1'b1);
    chk(t + 8, 1, SEL_BUSY, 1'b1);
    chk(t + 9, 1, SEL_BUSY, 1'b0);
    exp_pulse(1, t + 13, 2, 1'b1);
    chk(t + 18, 1, SEL_BUSY, 1'b1);
    chk(t + 19, 1, SEL_BUSY, 1'b0);
    trig_at(1, t);
    trig_at(1, t + 6);
    trig_at(1, t + 10);
    cfg_holdoff = 8'd0;  // latched holdoff of the pulse in flight must stay 4
    wait_until(t + 24);
    clear_all();

    // Ch2 retriggerable: edges 5 apart give one 13-cycle pulse.
    set_ch(2, 0, 8);
    retrig[2] = 1'b1;
    t = cyc + 2;
    exp_pulse(2, t, 13, 1'b1);
    chk(t + 6, 2, SEL_MISSED, 1'b0);
    trig_at(2, t);
    trig_at(2, t + 5);
    wait_until(t + 16);

    // Ch2 non-retriggerable: 8 cycles and missed.
    retrig[2] = 1'b0;
    t = cyc + 2;
    exp_pulse(2, t, 8, 1'b1);
    chk(t + 4, 2, SEL_MISSED, 1'b0);
    chk(t + 5, 2, SEL_MISSED, 1'b1);
    trig_at(2, t);
    trig_at(2, t + 5);
    wait_until(t + 12);
    clear_all();

    // Ch3 disabled mid-pulse: drops next cycle, no done.
    set_ch(3, 0, 10);
    t = cyc + 2;
    exp_pulse(3, t, 2, 1'b0);
    chk(t + 2, 3, SEL_BUSY, 1'b0);
    trig_at(3, t);
    @(negedge clk);
    enable[3] = 1'b0;
    @(negedge clk);
    t2 = cyc + 2;
    chk(t2, 3, SEL_BUSY, 1'b0);
    chk(t2 + 1, 3, SEL_MISSED, 1'b0);
    trig_at(3, t2);
    wait_until(t2 + 2);
    trigger[3] = 1'b1;
    @(negedge clk);
    enable[3] = 1'b1;  // trigger already high: not an edge
    chk(cyc + 1, 3, SEL_BUSY, 1'b0);
    chk(cyc + 2, 3, SEL_PULSE, 1'b0);
    repeat (3) @(negedge clk);
    trigger[3] = 1'b0;
    @(negedge clk);

    // Reset mid-pulse on ch0.
    set_ch(0, 0, 10);
    t = cyc + 2;
    exp_pulse(0, t, 3, 1'b0);
    trig_at(0, t);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    chk_all_zero(cyc + 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // All channels together; missed edge on ch0 coincides with clear_missed.
    set_ch(0, 0, 3);
    set_ch(1, 1, 4);
    set_ch(2, 2, 5);
    set_ch(3, 3, 6);
    cfg_holdoff = 8'd2;
    t = cyc + 2;
    for (int c = 0; c < NUM_CH; c++) exp_pulse(c, t + c, c + 3, 1'b1);
    chk(t + 2, 0, SEL_MISSED, 1'b1);
    chk(t + 2, 1, SEL_MISSED, 1'b0);
    chk(t + 3, 0, SEL_BUSY, 1'b1);
    chk(t + 5, 0, SEL_BUSY, 1'b0);
    wait_until(t - 1);
    trigger = '1;
    @(negedge clk);
    trigger = '0;
    @(negedge clk);
    trigger[0]   = 1'b1;
    clear_missed = 1'b1;
    @(negedge clk);
    trigger[0]   = 1'b0;
    clear_missed = 1'b0;
    wait_until(t + 14);
    clear_all();

    // Max counts: D=4095 W=8191 H=255 exact, no wrap.
    set_ch(1, 4095, 8191);
    cfg_holdoff = 8'd255;
    t = cyc + 2;
    tend = t + 4095 + 8191 + 255;
    exp_pulse(1, t + 4095, 8191, 1'b1);
    chk(t + 4094, 1, SEL_PULSE, 1'b0);
    chk(tend - 1, 1, SEL_BUSY, 1'b1);
    chk(tend, 1, SEL_BUSY, 1'b0);
    trig_at(1, t);
    wait_until(tend + 2);

    stim_done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NUM_CH-1:0] prev_p = '0;
  int                start_c [NUM_CH];
  int                idx;
  logic              got;
  pexp_t             e;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (pulse[i] && !prev_p[i]) start_c[i] = cyc;
      if (!pulse[i] && prev_p[i]) begin
        idx = -1;
        for (int j = 0; j < sb_q.size(); j++)
          if (idx < 0 && sb_q[j].ch == i) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_pulse ch%0d: got rise %0d len %0d, none expected",
                   i, start_c[i], cyc - start_c[i]);
        end else begin
          e = sb_q[idx];
          sb_q.delete(idx);
          if (start_c[i] != e.rise || (cyc - start_c[i]) != e.len || done[i] != e.dn) begin
            errors++;
            $display("FAIL pulse_ch%0d: got rise %0d len %0d done %0b, want rise %0d len %0d done %0b",
                     i, start_c[i], cyc - start_c[i], done[i], e.rise, e.len, e.dn);
          end
        end
      end else if (done[i]) begin
        checks++;
        errors++;
        $display("FAIL stray_done ch%0d cycle %0d: got done 1, want 0", i, cyc);
      end
      prev_p[i] = pulse[i];
    end

    for (int j = lvl_q.size() - 1; j >= 0; j--) begin
      if (lvl_q[j].at == cyc) begin
        case (lvl_q[j].sel)
          SEL_PULSE: got = pulse[lvl_q[j].ch];
          SEL_BUSY:  got = busy[lvl_q[j].ch];
          SEL_DONE:  got = done[lvl_q[j].ch];
          default:   got = missed[lvl_q[j].ch];
        endcase
        checks++;
        if (got !== lvl_q[j].val) begin
          errors++;
          $display("FAIL %s ch%0d cycle %0d: got %0b want %0b", sel_name(lvl_q[j].sel),
                   lvl_q[j].ch, cyc, got, lvl_q[j].val);
        end
        lvl_q.delete(j);
      end
    end

    if (stim_done) begin
      checks++;
      if (sb_q.size() != 0 || lvl_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d pulses %0d levels pending, want 0 0",
                 sb_q.size(), lvl_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (cyc > 40000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got cycle %0d, want stimulus end before 40000", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
